blink_tick_scheduler: RTL and testbench
=======================================

// Module: blink_tick_scheduler
// PURPOSE
//  Shares one free-running prescaler among NUM_CH blink channels. Each channel has its own
//  half-period, counted in base ticks, and produces a toggling square wave plus a 1-cycle tick.
//  Software and top-level logic reprogram channels through a valid/ready config port. The
//  block sits between board control and the LED pins; it replaces per-LED 32-bit dividers.
// PARAMETERS
//  CLK_FREQ  12_000_000  input clock frequency, Hz
//  BASE_HZ   1000        base tick rate, Hz; PRE = CLK_FREQ/BASE_HZ (integer, >= 2)
//  NUM_CH    4           number of channels, 1..16
//  PER_W     16          width of per-channel half-period, in base ticks
// PORTS
//  clk         in   1                 system clock
//  rst         in   1                 synchronous reset, active-high
//  run         in   1                 global enable; 0 freezes prescaler and all channels
//  cfg_valid   in   1                 config request
//  cfg_ready   out  1                 config slot free
//  cfg_ch      in   $clog2(NUM_CH)>=1 target channel index
//  cfg_period  in   PER_W             new half-period, in base ticks; 0 = channel off
//  cfg_en      in   1                 new channel enable
//  base_tick   out  1                 1-cycle pulse at each prescaler wrap (registered)
//  ch_tick     out  NUM_CH            1-cycle pulse per channel toggle (registered)
//  ch_out      out  NUM_CH            channel square waves
// BEHAVIOUR
//  Reset: the following are 0: prescaler, all channel counters, periods, enables, ch_out,
//   ch_tick, base_tick, and cfg_ready. The config FSM resets to IDLE. cfg_ready goes 1 in the
//   first cycle after rst is released.
//  Prescaler: while run=1, counts 0..PRE-1 and wraps to 0. base_tick=1 in the cycle after the
//   counter holds PRE-1. While run=0, the counter holds and base_tick=0.
//  Channel active: en=1 and period!=0. An inactive channel holds cnt=0, ch_out=0, ch_tick=0.
//  Channel step (active, base_tick=1):
//   - if cnt>=period-1: cnt<=0, ch_out toggles, ch_tick=1 in the next cycle;
//   - otherwise: cnt<=cnt+1.
//   The comparison is unsigned PER_W-bit. cnt never exceeds PER_W bits.
//  Toggle timing: ch_out changes period*PRE clocks apart; full waveform period = 2*period*PRE.
//  Config FSM:
//   IDLE (cfg_ready=1): on cfg_valid=1, capture ch/period/en into the pending register, go to
//    PEND, and drop cfg_ready in the next cycle.
//   PEND (cfg_ready=0): apply on the first cycle where base_tick=1 or run=0.
//    Apply = period/en written, cnt<=0, ch_out<=0, ch_tick suppressed. Then go to IDLE.
//   Alignment: updates apply on a base-tick boundary, so waveforms restart phase-aligned
//    with the other channels.
//  Simultaneous events:
//   - Apply and a step on the same channel in the same cycle: apply wins; no toggle, no tick.
//   - Other channels step normally in that cycle.
//  cfg_ch >= NUM_CH: the request is accepted and dropped (no state change); FSM returns to
//   IDLE.
//  Reset mid-operation: rst in any cycle, including during PEND, discards the pending config
//   and enters the reset state in the next cycle.
//  cfg_* inputs are only sampled in IDLE while cfg_valid=1. Changes at other times are ignored.
// TESTING (bench uses CLK_FREQ=12, BASE_HZ=4 -> PRE=3)
//  1. Reset release, run=1, no config -> base_tick every 3 clks, ch_out=0, ch_tick=0,
//     cfg_ready=1.
//  2. Program ch0 period=2 en=1 -> cfg_ready low until apply; then ch_out[0] toggles every
//     6 clks and ch_tick[0] pulses with each toggle.
//  3. Apply coincides with ch0 terminal count -> no toggle that cycle; ch0 restarts from 0;
//     ch1 unaffected.
//  4. run=0 for 10 clks mid-count -> all outputs and counters frozen; with run=0, a config is
//     applied 1 clk after acceptance; the count resumes exactly on run=1.
//  5. period=0 with en=1, and cfg_ch=NUM_CH -> channel stays off; invalid request completes,
//     cfg_ready returns 1, no channel changes.
//  6. rst asserted during PEND -> pending config lost; all outputs 0; cfg_ready=1 one clk
//     after rst deasserts.

Source files
------------

// File: rtl/blink_tick_scheduler.sv
// blink_tick_scheduler
// One free-running prescaler produces base ticks shared by all channels. Each channel
// divides the base tick by its own half-period to drive a square wave and a one-cycle
// toggle pulse. Channels are reprogrammed through a single-slot valid/ready port; an
// update lands on a base-tick boundary (or at once while stopped), so the reprogrammed
// channel restarts phase-aligned with the channels that keep running.
module blink_tick_scheduler #(
   parameter  int CLK_FREQ = 12_000_000,
   parameter  int BASE_HZ  = 1000,
   parameter  int NUM_CH   = 4,
   parameter  int PER_W    = 16,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [PER_W-1:0]  cfg_period,
   input  logic              cfg_en,
   output logic              base_tick,
   output logic [NUM_CH-1:0] ch_tick,
   output logic [NUM_CH-1:0] ch_out
);

   localparam int PRE   = CLK_FREQ / BASE_HZ;
   localparam int PRE_W = (PRE > 1) ? $clog2(PRE) : 1;

   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRE - 1);
   localparam logic [PRE_W-1:0]  PRE_ONE   = PRE_W'(1'b1);
   localparam logic [PRE_W-1:0]  PRE_ZERO  = {PRE_W{1'b0}};
   localparam logic [PER_W-1:0]  PER_ONE   = PER_W'(1'b1);
   localparam logic [PER_W-1:0]  PER_ZERO  = {PER_W{1'b0}};
   localparam logic [CH_W:0]     NUM_CH_L  = (CH_W + 1)'(NUM_CH);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } cfg_state_t;

   // prescaler
   logic [PRE_W-1:0]  pre_cnt_r;
   logic              base_tick_r;

   // config slot
   cfg_state_t        state_r;
   logic              cfg_ready_r;
   logic [CH_W-1:0]   pend_ch_r;
   logic [PER_W-1:0]  pend_per_r;
   logic              pend_en_r;
   logic              pend_ok_r;

   // channel state
   logic [PER_W-1:0]  cnt_r [NUM_CH];
   logic [PER_W-1:0]  per_r [NUM_CH];
   logic [NUM_CH-1:0] en_r;
   logic [NUM_CH-1:0] out_r;
   logic [NUM_CH-1:0] tick_r;

   // combinational helpers
   logic              apply_s;
   logic [NUM_CH-1:0] hit_s;
   logic [NUM_CH-1:0] active_s;

   assign base_tick = base_tick_r;
   assign cfg_ready = cfg_ready_r;
   assign ch_tick   = tick_r;
   assign ch_out    = out_r;

   // Prescaler: count 0..PRE-1 while running, pulse base_tick the cycle after PRE-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt_r   <= PRE_ZERO;
         base_tick_r <= 1'b0;
      end else if (run) begin
         if (pre_cnt_r == PRE_LAST) begin
            pre_cnt_r   <= PRE_ZERO;
            base_tick_r <= 1'b1;
         end else begin
            pre_cnt_r   <= pre_cnt_r + PRE_ONE;
            base_tick_r <= 1'b0;
         end
      end else begin
         pre_cnt_r   <= pre_cnt_r;
         base_tick_r <= 1'b0;
      end
   end

   // A pending update lands on a base-tick boundary, or at once while the block is stopped.
   always_comb begin
      apply_s = 1'b0;
      if (state_r == ST_PEND) begin
         apply_s = base_tick_r | ~run;
      end else begin
         apply_s = 1'b0;
      end
   end

   // Decode which channel (if any) the landing update targets, and which channels run.
   always_comb begin
      hit_s    = {NUM_CH{1'b0}};
      active_s = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         if (apply_s && pend_ok_r && (pend_ch_r == CH_W'(i))) begin
            hit_s[i] = 1'b1;
         end else begin
            hit_s[i] = 1'b0;
         end
         if (en_r[i] && (per_r[i] != PER_ZERO)) begin
            active_s[i] = 1'b1;
         end else begin
            active_s[i] = 1'b0;
         end
      end
   end

   // Config slot FSM: accept one request in IDLE, hold it in PEND until it can land.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cfg_ready_r <= 1'b0;
         pend_ch_r   <= {CH_W{1'b0}};
         pend_per_r  <= PER_ZERO;
         pend_en_r   <= 1'b0;
         pend_ok_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (cfg_ready_r && cfg_valid) begin
                  // out-of-range channels are still accepted, but flagged so they land as no-ops
                  pend_ch_r   <= cfg_ch;
                  pend_per_r  <= cfg_period;
                  pend_en_r   <= cfg_en;
                  pend_ok_r   <= ({1'b0, cfg_ch} < NUM_CH_L);
                  state_r     <= ST_PEND;
                  cfg_ready_r <= 1'b0;
               end else begin
                  state_r     <= ST_IDLE;
                  cfg_ready_r <= 1'b1;
               end
            end
            ST_PEND: begin
               if (apply_s) begin
                  state_r     <= ST_IDLE;
                  cfg_ready_r <= 1'b1;
               end else begin
                  state_r     <= ST_PEND;
                  cfg_ready_r <= 1'b0;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               cfg_ready_r <= 1'b0;
            end
         endcase
      end
   end

   // Channel dividers: a landing update wins over a same-cycle step on that channel.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_r[i]  <= PER_ZERO;
            per_r[i]  <= PER_ZERO;
            en_r[i]   <= 1'b0;
            out_r[i]  <= 1'b0;
            tick_r[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (hit_s[i]) begin
               per_r[i]  <= pend_per_r;
               en_r[i]   <= pend_en_r;
               cnt_r[i]  <= PER_ZERO;
               out_r[i]  <= 1'b0;
               tick_r[i] <= 1'b0;
            end else if (!active_s[i]) begin
               cnt_r[i]  <= PER_ZERO;
               out_r[i]  <= 1'b0;
               tick_r[i] <= 1'b0;
            end else if (base_tick_r) begin
               // period is non-zero here, so period-1 cannot wrap
               if (cnt_r[i] >= (per_r[i] - PER_ONE)) begin
                  cnt_r[i]  <= PER_ZERO;
                  out_r[i]  <= ~out_r[i];
                  tick_r[i] <= 1'b1;
               end else begin
                  cnt_r[i]  <= cnt_r[i] + PER_ONE;
                  tick_r[i] <= 1'b0;
               end
            end else begin
               tick_r[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_blink_tick_scheduler.sv
// tb_blink_tick_scheduler
// Small configuration (PRE=3, three channels). A reference model built on counts of
// run-enabled clocks and base ticks since each channel was last programmed predicts every
// output every cycle; a table of hand-derived vectors and directed corner sequences add
// explicit expectations on top.
module tb_blink_tick_scheduler;

   localparam int NUM_CH = 3;
   localparam int PER_W  = 16;
   localparam int PRE    = 3;

   logic              clk = 1'b0;
   logic              r_rst = 1'b1;
   logic              r_run = 1'b1;
   logic              r_valid = 1'b0;
   logic [1:0]        r_ch = 2'd0;
   logic [PER_W-1:0]  r_per = 16'd0;
   logic              r_en = 1'b0;
   logic              cfg_ready;
   logic              base_tick;
   logic [NUM_CH-1:0] ch_tick;
   logic [NUM_CH-1:0] ch_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   blink_tick_scheduler #(
      .CLK_FREQ (12),
      .BASE_HZ  (4),
      .NUM_CH   (NUM_CH),
      .PER_W    (PER_W)
   ) dut (
      .clk        (clk),
      .rst        (r_rst),
      .run        (r_run),
      .cfg_valid  (r_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ch     (r_ch),
      .cfg_period (r_per),
      .cfg_en     (r_en),
      .base_tick  (base_tick),
      .ch_tick    (ch_tick),
      .ch_out     (ch_out)
   );

   // ---------------- reference model ----------------
   int m_n;                 // run-enabled clocks since reset
   bit m_bt;
   bit m_ready;
   bit m_pend;
   bit m_ok;
   int m_pch;
   int m_pper;
   bit m_pen;
   int m_k    [NUM_CH];     // base ticks consumed since the channel was programmed
   int m_per  [NUM_CH];
   bit m_en   [NUM_CH];
   bit m_tick [NUM_CH];

   function automatic logic [NUM_CH-1:0] m_out_vec();
      logic [NUM_CH-1:0] v;
      for (int i = 0; i < NUM_CH; i++) begin
         if (m_en[i] && m_per[i] != 0) v[i] = ((m_k[i] / m_per[i]) % 2) == 1;
         else v[i] = 1'b0;
      end
      return v;
   endfunction

   function automatic logic [NUM_CH-1:0] m_tick_vec();
      logic [NUM_CH-1:0] v;
      for (int i = 0; i < NUM_CH; i++) v[i] = m_tick[i];
      return v;
   endfunction

   task automatic model_step();
      bit bt0;
      bit apply;
      if (r_rst) begin
         m_n = 0; m_bt = 0; m_pend = 0; m_ready = 0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_k[i] = 0; m_per[i] = 0; m_en[i] = 0; m_tick[i] = 0;
         end
      end else begin
         bt0   = m_bt;
         apply = m_pend && (bt0 || !r_run);
         for (int i = 0; i < NUM_CH; i++) begin
            if (apply && m_ok && m_pch == i) begin
               m_per[i] = m_pper; m_en[i] = m_pen; m_k[i] = 0; m_tick[i] = 0;
            end else if (!(m_en[i] && m_per[i] != 0)) begin
               m_k[i] = 0; m_tick[i] = 0;
            end else if (bt0) begin
               m_k[i]    = m_k[i] + 1;
               m_tick[i] = (m_k[i] % m_per[i]) == 0;
            end else begin
               m_tick[i] = 0;
            end
         end
         if (r_run) begin
            m_n  = m_n + 1;
            m_bt = (m_n % PRE) == 0;
         end else begin
            m_bt = 0;
         end
         if (m_pend) begin
            if (apply) begin m_pend = 0; m_ready = 1; end
         end else if (!m_ready) begin
            m_ready = 1;
         end else if (r_valid) begin
            m_pend = 1; m_ready = 0;
            m_ok = int'(r_ch) < NUM_CH;
            m_pch = int'(r_ch); m_pper = int'(r_per); m_pen = r_en;
         end
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: DUT and model both take the edge, then outputs are compared at negedge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("m_base_tick", 32'(base_tick), 32'(m_bt));
      chk("m_ch_tick",   32'(ch_tick),   32'(m_tick_vec()));
      chk("m_ch_out",    32'(ch_out),    32'(m_out_vec()));
      chk("m_cfg_ready", 32'(cfg_ready), 32'(m_ready));
   endtask

   task automatic wait_ready(input string nm);
      bit ok;
      ok = cfg_ready;
      for (int j = 0; j < 30; j++) begin
         if (!ok) begin
            cycle();
            ok = cfg_ready;
         end
      end
      chk(nm, 32'(ok), 32'd1);
   endtask

   task automatic send_cfg(input logic [1:0] ch, input logic [PER_W-1:0] per, input logic en);
      wait_ready("cfg_wait_ready");
      r_valid = 1'b1; r_ch = ch; r_per = per; r_en = en;
      cycle();
      r_valid = 1'b0;
      chk("cfg_accept_drops_ready", 32'(cfg_ready), 32'd0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic             rst;
      logic             valid;
      logic             bt;
      logic [2:0]       tick;
      logic [2:0]       out;
      logic             rdy;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic rst, input logic valid, input logic bt,
                          input logic [2:0] tick, input logic [2:0] out, input logic rdy);
      vec_t v;
      v.rst = rst; v.valid = valid; v.bt = bt; v.tick = tick; v.out = out; v.rdy = rdy;
      vecs.push_back(v);
   endtask

   initial begin
      bit seen;
      bit quiet;
      bit frozen;
      logic [1:0] snap;

      // reset, free-running prescaler, then ch0 period 2 programmed mid-stream
      add_vec(1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
      add_vec(1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
      add_vec(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
      add_vec(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
      add_vec(1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b1);
      add_vec(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
      add_vec(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
      add_vec(1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b1);
      add_vec(1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
      add_vec(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
      add_vec(1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
      add_vec(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
      add_vec(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
      add_vec(1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b1);
      add_vec(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
      add_vec(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
      add_vec(1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b1);
      add_vec(1'b0, 1'b0, 1'b0, 3'b001, 3'b001, 1'b1);
      add_vec(1'b0, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1);
      add_vec(1'b0, 1'b0, 1'b1, 3'b000, 3'b001, 1'b1);
      add_vec(1'b0, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1);
      add_vec(1'b0, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1);
      add_vec(1'b0, 1'b0, 1'b1, 3'b000, 3'b001, 1'b1);
      add_vec(1'b0, 1'b0, 1'b0, 3'b001, 3'b000, 1'b1);

      for (int i = 0; i < vecs.size(); i++) begin
         r_rst = vecs[i].rst; r_run = 1'b1; r_valid = vecs[i].valid;
         r_ch = 2'd0; r_per = 16'd2; r_en = 1'b1;
         cycle();
         chk("vec_base_tick", 32'(base_tick), 32'(vecs[i].bt));
         chk("vec_ch_tick",   32'(ch_tick),   32'(vecs[i].tick));
         chk("vec_ch_out",    32'(ch_out),    32'(vecs[i].out));
         chk("vec_cfg_ready", 32'(cfg_ready), 32'(vecs[i].rdy));
      end
      r_valid = 1'b0;

      // apply lands on ch0 terminal count; ch1 (period 1) keeps stepping
      send_cfg(2'd1, 16'd1, 1'b1);
      wait_ready("t3_ch1_done");
      seen = 1'b0;
      for (int j = 0; j < 20; j++) begin
         if (!seen) begin
            cycle();
            seen = ch_tick[0];
         end
      end
      chk("t3_sync_ch0_tick", 32'(seen), 32'd1);
      repeat (3) cycle();
      r_valid = 1'b1; r_ch = 2'd0; r_per = 16'd3; r_en = 1'b1;
      cycle();
      r_valid = 1'b0;
      chk("t3_accept_ready", 32'(cfg_ready), 32'd0);
      cycle();
      cycle();
      chk("t3_no_tick_on_apply", 32'(ch_tick[0]), 32'd0);
      chk("t3_out_cleared",      32'(ch_out[0]),  32'd0);
      chk("t3_ch1_still_ticks",  32'(ch_tick[1]), 32'd1);
      chk("t3_ready_back",       32'(cfg_ready),  32'd1);
      quiet = 1'b1;
      for (int j = 0; j < 8; j++) begin
         cycle();
         if (ch_out[0] !== 1'b0 || ch_tick[0] !== 1'b0) quiet = 1'b0;
      end
      chk("t3_hold_9clk", 32'(quiet), 32'd1);
      cycle();
      chk("t3_first_toggle_out",  32'(ch_out[0]),  32'd1);
      chk("t3_first_toggle_tick", 32'(ch_tick[0]), 32'd1);

      // freeze for 10 clocks; a config accepted while stopped lands one clock later
      for (int j = 0; j < 4; j++) begin
         if (base_tick) cycle();
      end
      snap = ch_out[1:0];
      r_run = 1'b0;
      frozen = 1'b1;
      cycle();
      if (ch_out[1:0] !== snap || base_tick !== 1'b0 || ch_tick !== 3'b000) frozen = 1'b0;
      r_valid = 1'b1; r_ch = 2'd2; r_per = 16'd2; r_en = 1'b1;
      cycle();
      r_valid = 1'b0;
      chk("t4_accept_ready", 32'(cfg_ready), 32'd0);
      if (ch_out[1:0] !== snap || base_tick !== 1'b0 || ch_tick !== 3'b000) frozen = 1'b0;
      cycle();
      chk("t4_applied_next_clk", 32'(cfg_ready), 32'd1);
      for (int j = 0; j < 7; j++) begin
         if (ch_out[1:0] !== snap || base_tick !== 1'b0 || ch_tick !== 3'b000) frozen = 1'b0;
         cycle();
      end
      chk("t4_frozen", 32'(frozen), 32'd1);
      r_run = 1'b1;
      repeat (20) cycle();

      // period 0 keeps a channel off; an out-of-range channel is accepted and dropped
      send_cfg(2'd2, 16'd0, 1'b1);
      wait_ready("t5_off_done");
      send_cfg(2'd3, 16'd1, 1'b1);
      wait_ready("t5_invalid_done");
      quiet = 1'b1;
      for (int j = 0; j < 15; j++) begin
         cycle();
         if (ch_out[2] !== 1'b0 || ch_tick[2] !== 1'b0) quiet = 1'b0;
      end
      chk("t5_ch2_stays_off", 32'(quiet), 32'd1);

      // reset while a config is pending
      send_cfg(2'd0, 16'd1, 1'b1);
      r_rst = 1'b1;
      cycle();
      chk("t6_rst_base_tick", 32'(base_tick), 32'd0);
      chk("t6_rst_ch_out",    32'(ch_out),    32'd0);
      chk("t6_rst_ch_tick",   32'(ch_tick),   32'd0);
      chk("t6_rst_ready",     32'(cfg_ready), 32'd0);
      r_rst = 1'b0;
      cycle();
      chk("t6_ready_after_rst", 32'(cfg_ready), 32'd1);
      quiet = 1'b1;
      for (int j = 0; j < 12; j++) begin
         cycle();
         if (ch_out !== 3'b000 || ch_tick !== 3'b000) quiet = 1'b0;
      end
      chk("t6_pending_lost", 32'(quiet), 32'd1);

      // randomized traffic against the model
      for (int j = 0; j < 3000; j++) begin
         r_rst   = ($urandom_range(0, 499) == 0);
         r_run   = ($urandom_range(0, 9) != 0);
         r_valid = ($urandom_range(0, 3) == 0);
         r_ch    = 2'($urandom_range(0, 3));
         r_per   = 16'($urandom_range(0, 4));
         r_en    = ($urandom_range(0, 4) != 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
